subtraction_14bits: RTL and testbench

Pipelined 14-bit subtractor computing Diff = Ain − Bin as Ain + ~Bin + 1 through seven 2-bit carry-chained slices. It accepts a new operand pair every cycle and produces the difference, an unsigned borrow flag and a signed overflow flag at a fixed latency. It pairs with the existing 14-bit pipelined adder in the waveform datapath: phase/amplitude differencing and offset removal. A valid bit travels alongside the data so downstream stages know which results are real.

---
 rtl/subtraction_14bits_pkg.sv | 7 +
 rtl/subtraction_2bits.sv | 29 ++
 rtl/subtraction_14bits.sv | 126 ++++++++++++
 tb/tb_subtraction_14bits.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/subtraction_14bits_pkg.sv
// Shared constants for the pipelined 14-bit subtractor and its 2-bit slices.
package subtraction_14bits_pkg;
    localparam int WIDTH   = 14;
    localparam int SLICE_W = 2;
    localparam int N_SLICE = WIDTH / SLICE_W;
    localparam int LATENCY = N_SLICE + 1;
endpackage

// File: rtl/subtraction_2bits.sv
// One 2-bit slice of the subtractor: registered a + b_inv + cin, where b_inv is the
// already-inverted subtrahend slice (the inversion is done before the skew chain).
module subtraction_2bits
    import subtraction_14bits_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_inv_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);
    logic [SLICE_W:0] total_d;

    always_comb begin
        total_d = {1'b0, a_i} + {1'b0, b_inv_i} + {{SLICE_W{1'b0}}, cin_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_o  <= '0;
            cout_o <= 1'b0;
        end else begin
            sum_o  <= total_d[SLICE_W-1:0];
            cout_o <= total_d[SLICE_W];
        end
    end
endmodule

// File: rtl/subtraction_14bits.sv
// Pipelined 14-bit subtractor: seven carry-chained 2-bit slices with input skew and
// output deskew, fixed 8-cycle latency, one operation per cycle, no backpressure.
module subtraction_14bits
    import subtraction_14bits_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_valid,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] Diff_out,
    output logic             Borrow_out,
    output logic             Overflow_out,
    output logic             Out_valid
);
    logic [WIDTH-1:0]   bin_inv;
    logic [SLICE_W-1:0] a_sl   [N_SLICE];
    logic [SLICE_W-1:0] nb_sl  [N_SLICE];
    logic [SLICE_W-1:0] sum_w  [N_SLICE];
    logic [SLICE_W-1:0] sum_al [N_SLICE];
    logic               cin_w  [N_SLICE];
    logic               cout_w [N_SLICE];

    assign bin_inv = ~Bin;

    // Slice k sees its operands k cycles late, exactly when slice k-1's carry for the
    // same operation is sitting in its carry register.
    for (genvar k = 0; k < N_SLICE; k++) begin : g_slice
        localparam int SKEW   = k;
        localparam int DESKEW = N_SLICE - 1 - k;

        if (SKEW == 0) begin : g_no_skew
            assign a_sl[k]  = Ain[SLICE_W*k +: SLICE_W];
            assign nb_sl[k] = bin_inv[SLICE_W*k +: SLICE_W];
            assign cin_w[k] = 1'b1;
        end else begin : g_skew
            logic [SLICE_W-1:0] a_q  [SKEW];
            logic [SLICE_W-1:0] nb_q [SKEW];

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < SKEW; i++) begin
                        a_q[i]  <= '0;
                        nb_q[i] <= '0;
                    end
                end else begin
                    a_q[0]  <= Ain[SLICE_W*k +: SLICE_W];
                    nb_q[0] <= bin_inv[SLICE_W*k +: SLICE_W];
                    for (int i = 1; i < SKEW; i++) begin
                        a_q[i]  <= a_q[i-1];
                        nb_q[i] <= nb_q[i-1];
                    end
                end
            end

            assign a_sl[k]  = a_q[SKEW-1];
            assign nb_sl[k] = nb_q[SKEW-1];
            assign cin_w[k] = cout_w[k-1];
        end

        subtraction_2bits u_slice (
            .clk_i   (Clock),
            .rst_ni  (Reset),
            .a_i     (a_sl[k]),
            .b_inv_i (nb_sl[k]),
            .cin_i   (cin_w[k]),
            .sum_o   (sum_w[k]),
            .cout_o  (cout_w[k])
        );

        if (DESKEW == 0) begin : g_no_deskew
            assign sum_al[k] = sum_w[k];
        end else begin : g_deskew
            logic [SLICE_W-1:0] s_q [DESKEW];

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < DESKEW; i++) begin
                        s_q[i] <= '0;
                    end
                end else begin
                    s_q[0] <= sum_w[k];
                    for (int i = 1; i < DESKEW; i++) begin
                        s_q[i] <= s_q[i-1];
                    end
                end
            end

            assign sum_al[k] = s_q[DESKEW-1];
        end
    end

    logic [WIDTH-1:0]   diff_al;
    logic               a_msb_q;
    logic               b_msb_q;
    logic [LATENCY-1:0] valid_q;

    always_comb begin
        diff_al = '0;
        for (int k = 0; k < N_SLICE; k++) begin
            diff_al[SLICE_W*k +: SLICE_W] = sum_al[k];
        end
    end

    // Operand sign bits are captured alongside the top slice so overflow compares the
    // signs of the same operation whose result MSB lands in that slice.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            Diff_out     <= '0;
            Borrow_out   <= 1'b0;
            Overflow_out <= 1'b0;
            valid_q      <= '0;
        end else begin
            a_msb_q      <= a_sl[N_SLICE-1][SLICE_W-1];
            b_msb_q      <= ~nb_sl[N_SLICE-1][SLICE_W-1];
            Diff_out     <= diff_al;
            Borrow_out   <= ~cout_w[N_SLICE-1];
            Overflow_out <= (a_msb_q != b_msb_q) && (sum_w[N_SLICE-1][SLICE_W-1] != a_msb_q);
            valid_q      <= {valid_q[LATENCY-2:0], In_valid};
        end
    end

    assign Out_valid = valid_q[LATENCY-1];
endmodule

// File: tb/tb_subtraction_14bits.sv
// Self-checking bench for subtraction_14bits: directed vectors, back-to-back stream,
// randomized stream against an arithmetic reference model, and mid-stream reset.
module tb_subtraction_14bits;
    import subtraction_14bits_pkg::*;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             In_valid;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] Diff_out;
    logic             Borrow_out;
    logic             Overflow_out;
    logic             Out_valid;

    int tests = 0;
    int fails = 0;

    subtraction_14bits dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .In_valid     (In_valid),
        .Ain          (Ain),
        .Bin          (Bin),
        .Diff_out     (Diff_out),
        .Borrow_out   (Borrow_out),
        .Overflow_out (Overflow_out),
        .Out_valid    (Out_valid)
    );

    // ---------------- clock / watchdog ----------------
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } vec_t;

    vec_t vecs[7];
    vec_t stream[3];
    logic [2*WIDTH:0] exp_q[$];  // {valid, a, b} per cycle
    int ops;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk14(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] d, output logic br, output logic ov);
        int ua, ub, sa, sb, ud, sd;
        ua = int'(a);
        ub = int'(b);
        sa = a[WIDTH-1] ? ua - 16384 : ua;
        sb = b[WIDTH-1] ? ub - 16384 : ub;
        ud = ua - ub;
        sd = sa - sb;
        d  = ud[WIDTH-1:0];
        br = (ud < 0);
        ov = (sd > 8191) || (sd < -8192);
    endfunction

    task automatic check_outputs(input string tag, input vec_t v);
        chk14({tag, ".diff"}, Diff_out, v.diff);
        chk1({tag, ".borrow"}, Borrow_out, v.borrow);
        chk1({tag, ".ovf"}, Overflow_out, v.ovf);
    endtask

    task automatic run_single(input string tag, input vec_t v);
        Ain      = v.a;
        Bin      = v.b;
        In_valid = 1'b1;
        for (int c = 1; c <= LATENCY + 1; c++) begin
            step();
            In_valid = 1'b0;
            Ain      = 14'($urandom);
            Bin      = 14'($urandom);
            chk1({tag, ".valid"}, Out_valid, c == LATENCY);
            if (c == LATENCY) check_outputs(tag, v);
        end
    endtask

    task automatic rand_cycle(input logic allow);
        logic             v;
        logic [WIDTH-1:0] a, b, d;
        logic             br, ov;
        logic [2*WIDTH:0] e;
        v        = allow && ($urandom_range(0, 3) != 0);
        a        = 14'($urandom);
        b        = 14'($urandom);
        if ($urandom_range(0, 15) == 0) b = a;
        In_valid = v;
        Ain      = a;
        Bin      = b;
        step();
        if (v) ops++;
        exp_q.push_back({v, a, b});
        if (exp_q.size() == LATENCY) begin
            e = exp_q.pop_front();
            chk1("rand.valid", Out_valid, e[2*WIDTH]);
            if (e[2*WIDTH]) begin
                model(e[2*WIDTH-1:WIDTH], e[WIDTH-1:0], d, br, ov);
                chk14("rand.diff", Diff_out, d);
                chk1("rand.borrow", Borrow_out, br);
                chk1("rand.ovf", Overflow_out, ov);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk14({tag, ".diff"}, Diff_out, '0);
        chk1({tag, ".borrow"}, Borrow_out, 1'b0);
        chk1({tag, ".ovf"}, Overflow_out, 1'b0);
        chk1({tag, ".valid"}, Out_valid, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{a: 14'd100,    b: 14'd37,     diff: 14'd63,    borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 14'h0000,   b: 14'h0001,   diff: 14'h3FFF,  borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 14'h2000,   b: 14'h0001,   diff: 14'h1FFF,  borrow: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 14'h1FFF,   b: 14'h3FFF,   diff: 14'h2000,  borrow: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 14'h1234,   b: 14'h1234,   diff: 14'h0000,  borrow: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 14'h0000,   b: 14'h2000,   diff: 14'h2000,  borrow: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 14'h3FFF,   b: 14'h3FFF,   diff: 14'h0000,  borrow: 1'b0, ovf: 1'b0};

        stream[0] = '{a: 14'd3,    b: 14'd4,      diff: 14'h3FFF,  borrow: 1'b1, ovf: 1'b0};
        stream[1] = '{a: 14'h3FFF, b: 14'h0000,   diff: 14'h3FFF,  borrow: 1'b0, ovf: 1'b0};
        stream[2] = '{a: 14'h2AAA, b: 14'h1555,   diff: 14'h1555,  borrow: 1'b0, ovf: 1'b1};

        // Reset state
        Reset    = 1'b0;
        In_valid = 1'b0;
        Ain      = '0;
        Bin      = '0;
        repeat (3) step();
        chk_all_zero("reset");
        Reset = 1'b1;
        step();

        // Directed vectors, one isolated pulse each
        for (int i = 0; i < 7; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back stream: results must land on consecutive cycles
        for (int c = 1; c <= LATENCY + 3; c++) begin
            if (c <= 3) begin
                In_valid = 1'b1;
                Ain      = stream[c-1].a;
                Bin      = stream[c-1].b;
            end else begin
                In_valid = 1'b0;
                Ain      = 14'($urandom);
                Bin      = 14'($urandom);
            end
            step();
            chk1("b2b.valid", Out_valid, (c >= LATENCY) && (c <= LATENCY + 2));
            if (c >= LATENCY && c <= LATENCY + 2) begin
                check_outputs($sformatf("b2b%0d", c - LATENCY), stream[c-LATENCY]);
            end
        end

        // Random stream with gaps
        ops = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 4000 && ops < 1000; cyc++) rand_cycle(1'b1);
        repeat (LATENCY) rand_cycle(1'b0);

        // Reset mid-stream with 5 operations in flight
        for (int i = 0; i < 5; i++) begin
            In_valid = 1'b1;
            Ain      = 14'($urandom);
            Bin      = 14'($urandom);
            step();
        end
        In_valid = 1'b0;
        Reset    = 1'b0;
        #1;
        chk_all_zero("rst_now");
        step();
        step();
        chk_all_zero("rst_hold");
        Reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk1("rst_stale.valid", Out_valid, 1'b0);
        end
        run_single("post_rst", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
